// File: rtl/vdf_seq_pkg.sv
// Shared types and helpers for the repeated-squaring sequencer.
// Exports: seq_state_t (controller state encoding), SQ_BITS (widest supported
// operand) and sq_trunc (low half of a double-width product).
package vdf_seq_pkg;

  // Widest operand the truncation helper handles. Narrower operands are
  // zero-extended before truncation and then cut down again.
  localparam int unsigned SQ_BITS = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Reduction mod 2^SQ_BITS is plain truncation of the product.
  function automatic logic [SQ_BITS-1:0] sq_trunc(input logic [2*SQ_BITS-1:0] prod);
    return SQ_BITS'(prod);
  endfunction

endpackage

// File: rtl/vdf_square_seq.sv
// Computes y = x^(2^T) mod 2^BITS by driving T serial squarings through an
// external multiplier over its val/rdy operand and product ports.
// Ports: i_clk/i_rst (sync, active-high); job in i_val/o_rdy/i_dat/i_iter;
//   result out o_val/i_rdy/o_dat; multiplier operands o_mul_val/i_mul_rdy/
//   o_mul_dat_a/o_mul_dat_b; product i_mul_val/o_mul_rdy/i_mul_dat;
//   status o_busy (not idle) and o_cnt (squarings remaining).
module vdf_square_seq
  import vdf_seq_pkg::*;
#(
  parameter int unsigned BITS   = 1024,  // must not exceed SQ_BITS
  parameter int unsigned ITER_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // job in
  input  logic                i_val,
  output logic                o_rdy,
  input  logic [BITS-1:0]     i_dat,
  input  logic [ITER_W-1:0]   i_iter,
  // result out
  output logic                o_val,
  input  logic                i_rdy,
  output logic [BITS-1:0]     o_dat,
  // multiplier operand port
  output logic                o_mul_val,
  input  logic                i_mul_rdy,
  output logic [BITS-1:0]     o_mul_dat_a,
  output logic [BITS-1:0]     o_mul_dat_b,
  // multiplier product port
  input  logic                i_mul_val,
  output logic                o_mul_rdy,
  input  logic [2*BITS-1:0]   i_mul_dat,
  // status
  output logic                o_busy,
  output logic [ITER_W-1:0]   o_cnt
);

  seq_state_t          state_q, state_d;
  logic [BITS-1:0]     value_q, value_d;
  logic [ITER_W-1:0]   cnt_q,   cnt_d;
  logic [2*SQ_BITS-1:0] prod_ext;

  // Zero-extending to the helper's width keeps the low BITS of the product
  // intact, so truncating afterwards still yields product mod 2^BITS.
  assign prod_ext = (2*SQ_BITS)'(i_mul_dat);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_val) begin
          value_d = i_dat;
          cnt_d   = i_iter;
          state_d = (i_iter != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (i_mul_rdy) state_d = WAIT;
      end
      WAIT: begin
        // cnt_q is at least 1 here, so the decrement never wraps.
        if (i_mul_val) begin
          value_d = BITS'(sq_trunc(prod_ext));
          cnt_d   = cnt_q - ITER_W'(1);
          state_d = (cnt_q != ITER_W'(1)) ? ISSUE : DONE;
        end
      end
      DONE: begin
        if (i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs come straight from registers; value_q only changes in IDLE
  // and WAIT, so operands and result stay put while their valid is pending.
  assign o_rdy       = (state_q == IDLE);
  assign o_mul_val   = (state_q == ISSUE);
  assign o_mul_rdy   = (state_q == WAIT);
  assign o_val       = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
  assign o_dat       = value_q;
  assign o_mul_dat_a = value_q;
  assign o_mul_dat_b = value_q;
  assign o_cnt       = cnt_q;

endmodule
